calc_core: RTL and testbench
============================

CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter WIDTH, default 12, operand width in bits, signed two's complement; legal range 4..32.
REQ-002 Parameter OPW, default 4, opcode width in bits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 opcode  input  OPW  0=add, 1=sub, 2=mul, 3=div; all other codes are invalid.
REQ-007 a  input  WIDTH  signed operand A.
REQ-008 b  input  WIDTH  signed operand B.
REQ-009 chain  input  1  when high at accept, replaces A with the previous result.
REQ-010 abort  input  1  synchronous cancel of the operation in flight.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse; result and error valid.
REQ-013 result  output  2*WIDTH  signed result, held until the next done.
REQ-014 error  output  1  error status of the last completed operation.

Function
REQ-015 FSM states IDLE, EXEC, DONE; the state encoding is internal.
REQ-016 Accept: in IDLE with start=1, register opcode, A and B (A per REQ-024), clear error, go to EXEC.
REQ-017 Add/sub: EXEC lasts 1 cycle; result is the 2*WIDTH sign-extended sum or difference; overflow is impossible.
REQ-018 Mul: EXEC lasts WIDTH cycles of shift-add on operand magnitudes; sign is applied in the final cycle.
REQ-019 Div: EXEC lasts WIDTH cycles of restoring division on magnitudes; quotient truncates toward zero; quotient sign is sign(A) xor sign(B).
REQ-020 Latency: with accept at edge k, done=1 during the cycle after edge k+2 (add/sub/invalid/error) or k+WIDTH+1 (mul/div).
REQ-021 busy=1 from the edge after accept through the done cycle inclusive; busy=0 in IDLE.
REQ-022 DONE lasts exactly 1 cycle, then IDLE; a start in the DONE cycle is ignored.
REQ-023 A start while busy=1 is ignored; opcode, a and b changes while busy have no effect.
REQ-024 chain=1 at accept: A := last result. If the last result lies outside the WIDTH-bit signed range: error=1, result=0, and latency follows the add path.
REQ-025 Invalid opcode: error=1, result=0, add-path latency.
REQ-026 Div by B=0: error=1, result=0; WIDTH-cycle latency retained.
REQ-027 Most-negative operands: magnitude is computed in WIDTH unsigned bits, so results are exact (e.g. -2^(W-1) / -1 = +2^(W-1)).
REQ-028 abort=1 in EXEC: go to IDLE next edge; no done pulse; result and error keep their previous values.
REQ-029 abort in IDLE or DONE has no effect; abort and start together in IDLE: start wins.
REQ-030 error is stable outside done, until the next accept.

Reset
REQ-031 RST=1 forces IDLE, busy=0, done=0, result=0, error=0, and clears the chain source to 0, immediately and independent of CLK.
REQ-032 RST asserted mid-EXEC discards the operation; no done pulse follows release.
REQ-033 The first accept is possible on the first rising edge after RST deasserts.

Configuration
REQ-034 Macro CALC_CORE_DIV_EN: when defined, opcode 3 performs division per REQ-019/026.
REQ-035 Without CALC_CORE_DIV_EN: no divider logic is synthesised, and opcode 3 is treated as invalid per REQ-025.

Verification
REQ-036 WIDTH=12, add a=-5, b=3 -> done 2 cycles after accept, result=-2 (24'hFFFFFE), error=0.
REQ-037 mul a=-2047, b=2047 -> done at accept+13, result=-4190209, busy high 13 cycles.
REQ-038 div a=-7, b=2 -> result=-3; div a=100, b=0 -> error=1, result=0; with macro undefined, div 6/2 -> error=1.
REQ-039 mul 3*4, then pulse start (add, 99, 1) during busy -> ignored; only one done, result=12. Then chain add b=1 -> result=13.
REQ-040 mul 2047*2047, then chain add -> error=1, result=0; abort at cycle 5 of a mul -> no done, prior result retained.
REQ-041 RST pulsed mid-div -> busy=0, result=0 immediately; the next add 1+1 returns 2 with normal latency.

Source files
------------

// File: rtl/calc_core.sv
// Sequential signed calculator: 1-cycle add/sub, WIDTH-cycle shift-add multiply and restoring divide.
// Division is built only when CALC_CORE_DIV_EN is defined; otherwise opcode 3 reports an error.
module calc_core #(
  parameter int WIDTH = 12,
  parameter int OPW   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [OPW-1:0]     opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               chain,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               error
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] K_ADD = 3'd0;
  localparam logic [2:0] K_SUB = 3'd1;
  localparam logic [2:0] K_MUL = 3'd2;
  localparam logic [2:0] K_ERR = 3'd4;
`ifdef CALC_CORE_DIV_EN
  localparam logic [2:0] K_DIV = 3'd3;
`endif

  logic [1:0]       state_reg;
  logic [2:0]       kind_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic             neg_reg;
  logic [RW-1:0]    mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [RW-1:0]    acc_reg;

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             chain_bad;
  logic [2:0]       kind_sel;
  logic [RW-1:0]    add_res;
  logic [RW-1:0]    sub_res;
  logic [RW-1:0]    acc_next;
  logic [RW-1:0]    mul_res;
  logic             last_step;

`ifdef CALC_CORE_DIV_EN
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             take;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [RW-1:0]    div_res;
`endif

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);

  // Operand selection and classification at accept time.
  always_comb begin
    a_eff     = chain ? result[WIDTH-1:0] : a;
    // Previous result fits WIDTH signed bits only if its top WIDTH+1 bits agree.
    chain_bad = chain && !((&result[RW-1:WIDTH-1]) || ~(|result[RW-1:WIDTH-1]));
    a_mag     = a_eff[WIDTH-1] ? (WIDTH'(0) - a_eff) : a_eff;
    b_mag     = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    kind_sel  = K_ERR;
    if (!chain_bad) begin
      if (opcode == OPW'(0))      kind_sel = K_ADD;
      else if (opcode == OPW'(1)) kind_sel = K_SUB;
      else if (opcode == OPW'(2)) kind_sel = K_MUL;
`ifdef CALC_CORE_DIV_EN
      else if (opcode == OPW'(3)) kind_sel = K_DIV;
`endif
      else                        kind_sel = K_ERR;
    end
  end

  always_comb begin
    add_res   = {{WIDTH{opa_reg[WIDTH-1]}}, opa_reg} + {{WIDTH{opb_reg[WIDTH-1]}}, opb_reg};
    sub_res   = {{WIDTH{opa_reg[WIDTH-1]}}, opa_reg} - {{WIDTH{opb_reg[WIDTH-1]}}, opb_reg};
    acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    mul_res   = neg_reg ? (RW'(0) - acc_next) : acc_next;
    last_step = (cnt_reg == CW'(WIDTH - 1));
  end

`ifdef CALC_CORE_DIV_EN
  // One restoring-division step: remainder stays below the divisor, so the
  // sign bit of the WIDTH+1 bit difference decides whether to subtract.
  always_comb begin
    rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvsr_reg};
    take      = ~rem_diff[WIDTH];
    rem_next  = take ? rem_diff : rem_shift;
    quo_next  = {quo_reg[WIDTH-2:0], take};
    div_res   = neg_reg ? (RW'(0) - {{WIDTH{1'b0}}, quo_next}) : {{WIDTH{1'b0}}, quo_next};
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      kind_reg   <= K_ADD;
      cnt_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      neg_reg    <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      result     <= '0;
      error      <= 1'b0;
`ifdef CALC_CORE_DIV_EN
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvsr_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_EXEC;
            kind_reg   <= kind_sel;
            cnt_reg    <= '0;
            opa_reg    <= a_eff;
            opb_reg    <= b;
            neg_reg    <= a_eff[WIDTH-1] ^ b[WIDTH-1];
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            acc_reg    <= '0;
            error      <= 1'b0;
`ifdef CALC_CORE_DIV_EN
            rem_reg    <= '0;
            quo_reg    <= a_mag;
            dvsr_reg   <= b_mag;
`endif
          end
        end
        S_EXEC: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else begin
            case (kind_reg)
              K_ADD: begin
                result    <= add_res;
                state_reg <= S_DONE;
              end
              K_SUB: begin
                result    <= sub_res;
                state_reg <= S_DONE;
              end
              K_MUL: begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CW'(1);
                if (last_step) begin
                  result    <= mul_res;
                  state_reg <= S_DONE;
                end
              end
`ifdef CALC_CORE_DIV_EN
              K_DIV: begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
                cnt_reg <= cnt_reg + CW'(1);
                if (last_step) begin
                  // Divide-by-zero still runs the full sequence, then reports.
                  if (dvsr_reg == '0) begin
                    result <= '0;
                    error  <= 1'b1;
                  end else begin
                    result <= div_res;
                  end
                  state_reg <= S_DONE;
                end
              end
`endif
              default: begin
                result    <= '0;
                error     <= 1'b1;
                state_reg <= S_DONE;
              end
            endcase
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// Randomized self-checking bench for calc_core against an integer reference model.
// Honors CALC_CORE_DIV_EN the same way the design does.
module tb_calc_core;

  localparam int W   = 12;
  localparam int OPW = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [OPW-1:0] opcode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           chain;
  logic           abort;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           error;

  int     tests = 0;
  int     fails = 0;
  longint last_res = 0;

  calc_core #(.WIDTH(W), .OPW(OPW)) dut (
    .CLK(clk), .RST(rst), .start(start), .opcode(opcode), .a(a), .b(b),
    .chain(chain), .abort(abort), .busy(busy), .done(done),
    .result(result), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint res_val();
    return longint'($signed(result));
  endfunction

  // Reference behaviour straight from the operation rules.
  function automatic void model(input int op, input longint av, input longint bv, input bit ch,
                                input longint prev, output longint r, output bit e, output int lat);
    longint opa;
    longint lo;
    longint hi;
    lo  = -(longint'(1) << (W - 1));
    hi  = (longint'(1) << (W - 1)) - 1;
    e   = 1'b0;
    r   = 0;
    lat = 2;
    opa = ch ? prev : av;
    if (ch && (prev < lo || prev > hi)) begin
      e = 1'b1;
    end else begin
      case (op)
        0: r = opa + bv;
        1: r = opa - bv;
        2: begin r = opa * bv; lat = W + 1; end
        3: begin
`ifdef CALC_CORE_DIV_EN
          lat = W + 1;
          if (bv == 0) e = 1'b1;
          else r = opa / bv;
`else
          e = 1'b1;
`endif
        end
        default: e = 1'b1;
      endcase
    end
  endfunction

  // One transaction: accept, watch busy until done, check latency/result/error.
  // poke re-asserts start during busy and in the done cycle; ab asserts abort with start.
  task automatic run_op(input int op, input longint av, input longint bv, input bit ch,
                        input bit poke, input bit ab);
    longint er;
    bit     ee;
    int     el;
    int     n;
    bit     seen;
    model(op, av, bv, ch, last_res, er, ee, el);
    @(negedge clk);
    start  = 1'b1;
    opcode = OPW'(op);
    a      = av[W-1:0];
    b      = bv[W-1:0];
    chain  = ch;
    abort  = ab;
    @(posedge clk);
    #1;
    start  = 1'b0;
    abort  = 1'b0;
    chain  = 1'($urandom_range(0, 1));
    opcode = OPW'($urandom);
    a      = W'($urandom);
    b      = W'($urandom);
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < W + 8) begin
      @(negedge clk);
      n++;
      if (poke && el > 3 && n == 2) begin
        start = 1'b1; opcode = OPW'(0); a = W'(99); b = W'(1);
      end
      if (poke && el > 3 && n == 3) start = 1'b0;
      if (done) seen = 1'b1;
      else check("busy_exec", longint'(busy), 1);
    end
    check("latency", seen ? longint'(n) : -1, longint'(el));
    check("busy_done", longint'(busy), 1);
    check("result", res_val(), er);
    check("error", longint'(error), longint'(ee));
    $display("[TB] op=%0d a=%0d b=%0d chain=%0b -> result=%0d error=%0b cycles=%0d",
             op, av, bv, ch, res_val(), error, n);
    last_res = er;
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", longint'(busy), 0);
    check("idle_done", longint'(done), 0);
    check("error_hold", longint'(error), longint'(ee));
    check("result_hold", res_val(), er);
  endtask

  task automatic abort_test();
    longint keep;
    int     dn;
    keep = last_res;
    dn   = 0;
    @(negedge clk);
    start = 1'b1; opcode = OPW'(2); a = W'(7); b = W'(9); chain = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    for (int n = 0; n < W + 4; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_done", longint'(dn), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_result", res_val(), keep);
    $display("[TB] abort mul 7*9 in cycle 5 -> result=%0d done_pulses=%0d", res_val(), dn);
  endtask

  task automatic reset_test();
    int dn;
    dn = 0;
    @(negedge clk);
    start = 1'b1; opcode = OPW'(3); a = W'(1000); b = W'(3); chain = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_result", res_val(), 0);
    check("rst_error", longint'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    last_res = 0;
    for (int n = 0; n < W + 4; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rst_no_done", longint'(dn), 0);
    $display("[TB] reset mid-op -> result=%0d done_pulses=%0d", res_val(), dn);
  endtask

  initial begin
    int     op;
    longint av;
    longint bv;
    bit     ch;
    rst = 1'b0; start = 1'b0; opcode = '0; a = '0; b = '0; chain = 1'b0; abort = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_result", res_val(), 0);
    check("reset_error", longint'(error), 0);
    rst = 1'b0;

    run_op(0, -5, 3, 1'b0, 1'b0, 1'b0);
    run_op(2, -2047, 2047, 1'b0, 1'b0, 1'b0);
    run_op(3, -7, 2, 1'b0, 1'b0, 1'b0);
    run_op(3, 100, 0, 1'b0, 1'b0, 1'b0);
    run_op(3, 6, 2, 1'b0, 1'b0, 1'b0);
    run_op(2, 3, 4, 1'b0, 1'b1, 1'b0);
    run_op(0, 0, 1, 1'b1, 1'b0, 1'b0);
    run_op(2, 2047, 2047, 1'b0, 1'b0, 1'b0);
    run_op(0, 0, 1, 1'b1, 1'b0, 1'b0);
    run_op(2, -2048, -2048, 1'b0, 1'b0, 1'b0);
    run_op(2, -2048, -1, 1'b0, 1'b0, 1'b0);
    run_op(3, -2048, -1, 1'b0, 1'b0, 1'b0);
    run_op(1, 2047, -2048, 1'b0, 1'b0, 1'b0);
    run_op(7, 1, 1, 1'b0, 1'b0, 1'b0);
    run_op(0, 40, 2, 1'b0, 1'b0, 1'b1);
    abort_test();
    reset_test();
    run_op(0, 1, 1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = (i % 13 == 12) ? 15 : int'($urandom_range(0, 5));
      av = longint'($urandom_range(0, 4095)) - 2048;
      bv = longint'($urandom_range(0, 4095)) - 2048;
      if (op == 3 && $urandom_range(0, 3) == 0) bv = 0;
      ch = ($urandom_range(0, 3) == 0);
      run_op(op, av, bv, ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
